ext_mem_arbiter: RTL

- Two-requester arbiter and sequencer for the single-port external data memory (memory_ext_1).
- Shares the memory between the core data port (requester C) and a DMA engine (requester D).
- Drives the memory's chip-select, write, address and write-data inputs.
- Tracks in-flight reads and returns read data to the requester that issued each read.
- Sits between the core/DMA and memory_ext_1; the memory itself is unchanged.

---
 rtl/ext_mem_pkg.sv | 27 ++
 rtl/ext_mem_rd_tag.sv | 67 ++++++
 rtl/ext_mem_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ext_mem_pkg.sv
// Shared definitions for the external data memory arbiter and its read tag pipe.
package ext_mem_pkg;

  // Default read latency of memory_ext_1: control latch plus output register.
  localparam int unsigned RD_LAT_DEF = 2;

  // Width of the starvation counter; wide enough for MAX_WAIT up to 15.
  localparam int unsigned WCNT_W = 4;

  // Arbitration states.
  typedef enum logic [1:0] {
    C_PRI  = 2'd0,
    D_PRI  = 2'd1,
    D_LOCK = 2'd2
  } arb_state_e;

  // Owner of an in-flight read.
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Saturating increment of the starvation counter.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v,
                                                input logic [WCNT_W-1:0] top);
    return (v >= top) ? top : v + WCNT_W'(1);
  endfunction

endpackage

// File: rtl/ext_mem_rd_tag.sv
// In-flight read tracker: shifts {valid, owner} alongside the memory read
// pipeline and steers the returning word to the requester that issued it.
module ext_mem_rd_tag
  import ext_mem_pkg::*;
#(
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned DMD_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_vld,
  input  logic                ld_own,
  input  logic [DMD_SIZE-1:0] m_rdt,
  output logic                c_rvld,
  output logic [DMD_SIZE-1:0] c_rdt,
  output logic                d_rvld,
  output logic [DMD_SIZE-1:0] d_rdt
);

  logic [RD_LAT-1:0]   vld_q;
  logic [RD_LAT-1:0]   own_q;
  logic                hit_c;
  logic                hit_d;
  logic [DMD_SIZE-1:0] c_rdt_q;
  logic [DMD_SIZE-1:0] d_rdt_q;

  // Tag shift register, loaded every edge; reset drops all pending reads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, ld_vld});
      own_q <= RD_LAT'({own_q, ld_own});
    end
  end

  // Last stage selects which requester sees the word on m_rdt this cycle.
  always_comb begin
    hit_c = reset & vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWN_C);
    hit_d = reset & vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == OWN_D);
  end

  // Hold each requester's last returned word between its own returns.
  always_ff @(posedge clk) begin
    if (!reset) begin
      c_rdt_q <= '0;
      d_rdt_q <= '0;
    end else begin
      if (hit_c) c_rdt_q <= m_rdt;
      if (hit_d) d_rdt_q <= m_rdt;
    end
  end

  // Return demux; everything reads as zero while reset is asserted.
  always_comb begin
    c_rvld = hit_c;
    d_rvld = hit_d;
    c_rdt  = '0;
    d_rdt  = '0;
    if (reset) begin
      c_rdt = hit_c ? m_rdt : c_rdt_q;
      d_rdt = hit_d ? m_rdt : d_rdt_q;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// Two-requester arbiter for the single-port external data memory: the core
// (C) and the DMA engine (D) share memory_ext_1, one access per cycle, with a
// starvation guard for D, a D burst lock, and per-owner read return.
module ext_mem_arbiter
  import ext_mem_pkg::*;
#(
  parameter int unsigned DMA_SIZE = 3,
  parameter int unsigned DMD_SIZE = 4,
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                c_req,
  input  logic                c_wrb,
  input  logic [DMA_SIZE-1:0] c_add,
  input  logic [DMD_SIZE-1:0] c_dt,
  output logic                c_gnt,
  output logic                c_rvld,
  output logic [DMD_SIZE-1:0] c_rdt,
  input  logic                d_req,
  input  logic                d_wrb,
  input  logic [DMA_SIZE-1:0] d_add,
  input  logic [DMD_SIZE-1:0] d_dt,
  input  logic                d_lock,
  output logic                d_gnt,
  output logic                d_rvld,
  output logic [DMD_SIZE-1:0] d_rdt,
  output logic                m_cslt,
  output logic                m_wrb,
  output logic [DMA_SIZE-1:0] m_add,
  output logic [DMD_SIZE-1:0] m_dt,
  input  logic [DMD_SIZE-1:0] m_rdt
);

  localparam logic [WCNT_W-1:0] WAIT_TOP = WCNT_W'(MAX_WAIT - 1);

  // Reject parameter values the counter and tag pipe cannot represent.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("ext_mem_arbiter: MAX_WAIT must be in 1..15");
  end
  if (RD_LAT < 1) begin : g_bad_rd_lat
    $error("ext_mem_arbiter: RD_LAT must be at least 1");
  end

  arb_state_e        state;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_inc;
  logic              contested;
  logic              rd_ld;
  logic              rd_own;

  // Grant decision for the current cycle; nobody is granted during reset.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      case (state)
        D_PRI: begin
          d_gnt = d_req;
          c_gnt = c_req & ~d_req;
        end
        D_LOCK: begin
          d_gnt = d_req;
        end
        default: begin
          c_gnt = c_req;
          d_gnt = d_req & ~c_req;
        end
      endcase
    end
  end

  always_comb begin
    contested = c_req & d_req;
    wait_inc  = sat_inc(wait_cnt, WAIT_TOP);
  end

  // Arbitration state and starvation counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= C_PRI;
      wait_cnt <= '0;
    end else begin
      case (state)
        C_PRI: begin
          if (d_gnt) begin
            wait_cnt <= '0;
            if (d_lock) state <= D_LOCK;
          end else if (contested) begin
            wait_cnt <= wait_inc;
            if (wait_inc == WAIT_TOP) state <= D_PRI;
          end
        end
        D_PRI: begin
          if (d_gnt) begin
            wait_cnt <= '0;
            state    <= d_lock ? D_LOCK : C_PRI;
          end
        end
        D_LOCK: begin
          if (d_gnt) wait_cnt <= '0;
          if (!d_lock || !d_req) begin
            state    <= C_PRI;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= C_PRI;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Memory port mux: the winner's request goes out in its grant cycle.
  always_comb begin
    m_cslt = c_gnt | d_gnt;
    m_wrb  = 1'b0;
    m_add  = '0;
    m_dt   = '0;
    if (c_gnt) begin
      m_wrb = c_wrb;
      m_add = c_add;
      m_dt  = c_dt;
    end else if (d_gnt) begin
      m_wrb = d_wrb;
      m_add = d_add;
      m_dt  = d_dt;
    end
  end

  // Tag issued alongside each access: only granted reads carry a valid tag.
  always_comb begin
    rd_ld  = (c_gnt & ~c_wrb) | (d_gnt & ~d_wrb);
    rd_own = d_gnt ? OWN_D : OWN_C;
  end

  ext_mem_rd_tag #(
    .RD_LAT   (RD_LAT),
    .DMD_SIZE (DMD_SIZE)
  ) u_rd_tag (
    .clk    (clk),
    .reset  (reset),
    .ld_vld (rd_ld),
    .ld_own (rd_own),
    .m_rdt  (m_rdt),
    .c_rvld (c_rvld),
    .c_rdt  (c_rdt),
    .d_rvld (d_rvld),
    .d_rdt  (d_rdt)
  );

endmodule
